// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory arbiter: default widths,
// port-select encoding and the word-alignment helper.
// The optional round-robin arbitration is enabled by defining MEM_ARB_ROUND_ROBIN_EN.
package mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic logic isMisaligned(input logic [1:0] addrLsb);
    return (addrLsb & WORD_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_arb_resp.sv
// Per-port response register: pulses rvalid for one cycle after each grant
// and holds the last rdata/err value while no response is being returned.
module mem_arb_resp
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fire,
  input  logic              i_err,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err
);

  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  // Capture the granted access result at the edge ending the grant cycle; hold otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= i_fire;
      if (i_fire) begin
        r_rdata <= i_err ? '0 : i_rdata;
        r_err   <= i_err;
      end
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
  assign o_err    = r_err;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing a single-port combinational-read memory between
// instruction fetch and load/store. One access per cycle, registered
// response one cycle after the grant, misaligned word accesses rejected
// without touching memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise
// data always beats fetch.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_err,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_d_err,
  output logic              o_mem_enable,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  logic              w_dWins;
  logic              w_ifGnt;
  logic              w_dGnt;
  logic              w_anyGnt;
  port_e             w_selPort;
  logic [ADDR_W-1:0] w_selAddr;
  logic              w_ifMisaligned;
  logic              w_dMisaligned;
  logic              w_selMisaligned;
  logic              w_memEnable;
  logic [DATA_W-1:0] w_ifRespData;
  logic [DATA_W-1:0] w_dRespData;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic  w_contended;
  port_e r_lastWinner;

  // On contention the port that did not win the previous contended grant goes first.
  always_comb begin
    w_contended = i_if_req & i_d_req;
    if (w_contended) begin
      w_dWins = (r_lastWinner == PORT_IF);
    end else begin
      w_dWins = i_d_req;
    end
  end

  // Remember the winner of each contended grant; reset leaves data favoured.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lastWinner <= PORT_IF;
    end else if (w_contended) begin
      r_lastWinner <= w_dWins ? PORT_D : PORT_IF;
    end
  end
`else
  // Fixed priority: any data request beats fetch.
  always_comb begin
    w_dWins = i_d_req;
  end
`endif

  // Grant decode: reset is the memory image load window, so nothing is granted there.
  always_comb begin
    w_dGnt   = ~i_rst & i_d_req & w_dWins;
    w_ifGnt  = ~i_rst & i_if_req & ~w_dGnt;
    w_anyGnt = w_dGnt | w_ifGnt;
  end

  // Select the winning port's address and decide whether the memory is actually touched.
  always_comb begin
    w_ifMisaligned  = isMisaligned(i_if_addr[1:0]);
    w_dMisaligned   = isMisaligned(i_d_addr[1:0]);
    w_selPort       = w_dGnt ? PORT_D : PORT_IF;
    w_selAddr       = w_dGnt ? i_d_addr : i_if_addr;
    w_selMisaligned = w_dGnt ? w_dMisaligned : w_ifMisaligned;
    w_memEnable     = w_anyGnt & ~w_selMisaligned;
  end

  // Memory pins are driven only for an aligned granted access; all zero otherwise.
  always_comb begin
    o_mem_enable = w_memEnable;
    o_mem_wr     = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    if (w_memEnable) begin
      o_mem_addr = w_selAddr;
      if (w_selPort == PORT_D) begin
        o_mem_wr    = i_d_we;
        o_mem_wdata = i_d_wdata;
      end
    end
  end

  // Read data offered to each response register; stores and rejected accesses return zero.
  always_comb begin
    w_ifRespData = '0;
    w_dRespData  = '0;
    if (w_ifGnt && !w_ifMisaligned) begin
      w_ifRespData = i_mem_rdata;
    end
    if (w_dGnt && !w_dMisaligned && !i_d_we) begin
      w_dRespData = i_mem_rdata;
    end
  end

  assign o_if_gnt = w_ifGnt;
  assign o_d_gnt  = w_dGnt;

  mem_arb_resp #(
    .DATA_W(DATA_W)
  ) u_ifResp (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_fire  (w_ifGnt),
    .i_err   (w_ifMisaligned),
    .i_rdata (w_ifRespData),
    .o_rvalid(o_if_rvalid),
    .o_rdata (o_if_rdata),
    .o_err   (o_if_err)
  );

  mem_arb_resp #(
    .DATA_W(DATA_W)
  ) u_dResp (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_fire  (w_dGnt),
    .i_err   (w_dMisaligned),
    .i_rdata (w_dRespData),
    .o_rvalid(o_d_rvalid),
    .o_rdata (o_d_rdata),
    .o_err   (o_d_err)
  );

endmodule
